muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV64M multiply/divide unit inside the execute stage, directly upstream of the memory stage. Accepts one operation at a time from the decoded execute bundle, stalls the front of the pipeline while busy, and delivers a 64-bit result that execute forwards as `aluout` to memory. Handles all M-extension special cases (divide-by-zero, signed overflow, W-forms) without software help.

## Interface
- No parameters. Widths are fixed by the `common` package: `word_t` = 64 bits.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; aborts any operation in flight
- start  in  1  request a new operation; sampled only in IDLE
- op  in  `muldiv_op_t` (4)  MUL, MULH, MULHSU, MULHU, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
- a  in  64  rs1 value; captured at start
- b  in  64  rs2 value; captured at start
- busy  out  1  operation in progress; execute stalls while high
- done  out  1  one-cycle pulse; `result` is valid
- result  out  64  final value; held from `done` until the next accepted start

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE with start=1 and flush=0: latch `op`, `a`, `b`. W-forms use `a[31:0]` and `b[31:0]`, sign- or zero-extended as the op requires.
  - Divide-by-zero and overflow (most-negative / -1, either width) go straight to DONE.
  - Other multiplies go to MUL; other divides go to DIV.
- MUL: radix-2 shift-add over a 128-bit product on operand magnitudes. Take the final sign from the op's signedness. Iterate 64 cycles (32 for MULW).
  - MUL/MULW return the low half. MULW sign-extends bit 31.
  - MULH*, MULHU return the high 64 bits.
- DIV: restoring division on magnitudes, 64 iterations (32 for W-forms).
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
  - W results are sign-extended from bit 31, including DIVUW and REMUW.
- Special cases:
  - Divide by zero: quotient = all ones (W: sign-extended 32'hFFFFFFFF); remainder = dividend.
  - Signed overflow: quotient = dividend; remainder = 0.
- DONE: `done`=1 and `result` is driven. Next state is IDLE.
- start while busy is ignored. Execute must hold start until `done`.
- flush has priority over everything. From any state, go to IDLE next cycle with no `done`, and leave `result` unchanged. flush and start in the same IDLE cycle: the start is dropped.
- Reset: state=IDLE, busy=0, done=0, result=0, iteration counter=0.

## Timing
- start accepted in cycle T.
- Iterative op: busy=1 in cycles T+1..T+N+1, with N = 64 or 32. `done` is high in T+N+1 (DONE state). The unit is back in IDLE at T+N+2, ready for a new start then.
- Special-case op: busy=1 and done=1 in T+1.
- busy is registered and never high in IDLE. done is only high in DONE.
- Counter is 7 bits, loaded with N-1 on entry and counting down to 0. The last iteration happens when the counter is 0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: all multiplies use a single registered 64x64 to 128 product. MUL transitions to DONE after one cycle, so done=1 at T+2.
  - Division is unchanged.
- Undefined: iterative shift-add multiplier as described above.
- Results are bit-identical in both builds.

## Structure
- `muldiv_op_t` enum and `muldiv_state_t` (IDLE, MUL, DIV, DONE) go in `pipes`.
- Sub-module `div_iter` holds the restoring divider datapath (remainder/quotient registers, one subtract per cycle).
- `muldiv_unit` holds the FSM, special-case detection, sign fix-up, the multiplier and W-form extension.

## Test plan
- DIV a=-7, b=2 -> done at T+65, result=-3. REM on the same operands -> result=-1.
- DIVU a=100, b=0 -> done at T+1, result=64'hFFFF_FFFF_FFFF_FFFF. REMU on the same operands -> result=100.
- DIV a=64'h8000_0000_0000_0000, b=-1 -> done at T+1, result=64'h8000_0000_0000_0000. REM on the same operands -> result=0.
- MULHU a=b=64'hFFFF_FFFF_FFFF_FFFF -> result=64'hFFFF_FFFF_FFFF_FFFE.
  - Timing: done at T+65 with the macro undefined, T+2 with `MULDIV_FAST_MUL_EN` defined.
- DIVUW a=64'h0000_0000_8000_0000, b=1 -> done at T+33, result=64'hFFFF_FFFF_8000_0000. MULW a=b=65536 -> result=0.
- Start DIV, assert flush at T+10 -> IDLE at T+11, no `done`, `result` keeps its old value.
  - A new MUL started at T+11 completes normally.
  - A start asserted at T+5 (while busy) is ignored.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
//   common : machine word width (word_t, 64 bits)
//   pipes  : muldiv_op_t operation encoding, muldiv_state_t FSM states,
//            iteration-count constants and small op-decode helpers.
package common;
  typedef logic [63:0] word_t;
endpackage

package pipes;
  import common::*;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_MULW   = 4'd4,
    OP_DIV    = 4'd5,
    OP_DIVU   = 4'd6,
    OP_REM    = 4'd7,
    OP_REMU   = 4'd8,
    OP_DIVW   = 4'd9,
    OP_DIVUW  = 4'd10,
    OP_REMW   = 4'd11,
    OP_REMUW  = 4'd12
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  // Counter preload values: N-1 for 64 and 32 iterations.
  localparam logic [6:0] ITER_D = 7'd63;
  localparam logic [6:0] ITER_W = 7'd31;

  function automatic logic op_is_div(muldiv_op_t o);
    return o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                     OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_is_w(muldiv_op_t o);
    return o inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_is_rem(muldiv_op_t o);
    return o inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  // MUL/MULW only need the low product bits, which do not depend on
  // signedness, so they are treated as unsigned throughout.
  function automatic logic op_a_signed(muldiv_op_t o);
    return o inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic op_b_signed(muldiv_op_t o);
    return o inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic word_t sext32(logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: restoring divider datapath, one trial subtract per cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            capture dividend/divisor magnitudes (start of a divide)
//   step            perform one iteration this cycle
//   w               32-bit divide: dividend is pre-shifted into the top half
//   dividend        unsigned dividend magnitude
//   divisor         unsigned divisor magnitude (non-zero)
//   quo_nxt         quotient after the current iteration (combinational)
//   rem_nxt         remainder after the current iteration (combinational)
// The *_nxt outputs let the caller take the final result in the same cycle
// as the last iteration instead of spending another cycle.
module div_iter
  import common::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  step,
  input  logic  w,
  input  word_t dividend,
  input  word_t divisor,
  output word_t quo_nxt,
  output word_t rem_nxt
);

  word_t       quo_q;
  word_t       rem_q;
  word_t       div_q;
  logic [64:0] rem_shift;
  logic [64:0] rem_diff;
  logic        fits;

  always_comb begin
    rem_shift = {rem_q, quo_q[63]};
    rem_diff  = rem_shift - {1'b0, div_q};
    fits      = (rem_shift >= {1'b0, div_q});
    // Remainder stays below the divisor, so bit 64 is always clear here.
    rem_nxt   = fits ? rem_diff[63:0] : rem_shift[63:0];
    quo_nxt   = {quo_q[62:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      div_q <= '0;
    end else if (load) begin
      quo_q <= w ? {dividend[31:0], 32'b0} : dividend;
      rem_q <= '0;
      div_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV64M multiply/divide unit for the execute stage.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   flush        abort any operation in flight (priority over everything)
//   start        request a new operation, sampled only in IDLE
//   op           muldiv_op_t encoding (4 bits)
//   a, b         rs1 / rs2 values, captured at start
//   busy         operation in progress (any state but IDLE)
//   done         one-cycle pulse in DONE; result valid
//   result       final value, held until the next accepted start
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle 64x64 multiply
// instead of the 64/32-step shift-add multiplier. Division is identical.
//
// state   | meaning
// IDLE    | waiting for start; result holds last value
// MUL     | multiply iterations (one cycle in fast build)
// DIV     | restoring divide iterations
// DONE    | done pulse, result valid
module muldiv_unit
  import common::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  muldiv_state_t state, state_n;

  muldiv_op_t op_in;
  logic       is_w, is_div, sgn_a, sgn_b, neg_a, neg_b;
  word_t      a_ext, b_ext, ma_in, mb_in, most_neg, spec_val, spec_res;
  logic       div_zero, div_ovf, special, accept;

  muldiv_op_t op_q;
  logic       neg_q, rneg_q;
  word_t      mb_q;
  logic [6:0] cnt_q;
  word_t      result_q;

  logic         run_mul, run_div, last, mul_last;
  logic [127:0] prod, prod_fix;
  word_t        mul_res, div_res, quo_nxt, rem_nxt, q_fix, r_fix, d_val;

`ifdef MULDIV_FAST_MUL_EN
  word_t ma_q;
`else
  logic [127:0] mcand_q, acc_q, acc_nxt;
`endif

  // Operand preparation for the incoming request.
  always_comb begin
    op_in  = muldiv_op_t'(op);
    is_w   = op_is_w(op_in);
    is_div = op_is_div(op_in);
    sgn_a  = op_a_signed(op_in);
    sgn_b  = op_b_signed(op_in);
    if (is_w) begin
      a_ext = sgn_a ? sext32(a[31:0]) : {32'b0, a[31:0]};
      b_ext = sgn_b ? sext32(b[31:0]) : {32'b0, b[31:0]};
    end else begin
      a_ext = a;
      b_ext = b;
    end
    neg_a    = sgn_a & a_ext[63];
    neg_b    = sgn_b & b_ext[63];
    ma_in    = neg_a ? -a_ext : a_ext;
    mb_in    = neg_b ? -b_ext : b_ext;
    // W operands are already sign-extended, so the 64-bit compares cover
    // both widths.
    most_neg = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & sgn_a & (a_ext == most_neg) & (b_ext == '1);
    special  = div_zero | div_ovf;
    if (op_is_rem(op_in))
      spec_val = div_zero ? a_ext : '0;
    else
      spec_val = div_zero ? '1 : a_ext;
    spec_res = is_w ? sext32(spec_val[31:0]) : spec_val;
  end

  assign accept  = (state == ST_IDLE) & start & ~flush;
  assign run_mul = (state == ST_MUL) & ~flush;
  assign run_div = (state == ST_DIV) & ~flush;
  assign last    = (cnt_q == 7'd0);

`ifdef MULDIV_FAST_MUL_EN
  assign mul_last = 1'b1;
  assign prod     = {64'b0, ma_q} * {64'b0, mb_q};
`else
  assign mul_last = last;
  assign acc_nxt  = acc_q + (mb_q[0] ? mcand_q : 128'b0);
  assign prod     = acc_nxt;
`endif

  // Sign fix-up and result selection.
  always_comb begin
    prod_fix = neg_q ? -prod : prod;
    if (op_q == OP_MUL)
      mul_res = prod_fix[63:0];
    else if (op_q == OP_MULW)
      mul_res = sext32(prod_fix[31:0]);
    else
      mul_res = prod_fix[127:64];

    q_fix   = neg_q ? -quo_nxt : quo_nxt;
    r_fix   = rneg_q ? -rem_nxt : rem_nxt;
    d_val   = op_is_rem(op_q) ? r_fix : q_fix;
    div_res = op_is_w(op_q) ? sext32(d_val[31:0]) : d_val;
  end

  div_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (accept & is_div & ~special),
    .step     (run_div),
    .w        (is_w),
    .dividend (ma_in),
    .divisor  (mb_in),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = special ? ST_DONE : (is_div ? ST_DIV : ST_MUL);
      ST_MUL:  if (mul_last) state_n = ST_DONE;
      ST_DIV:  if (last) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mb_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef MULDIV_FAST_MUL_EN
      ma_q     <= '0;
`else
      mcand_q  <= '0;
      acc_q    <= '0;
`endif
    end else begin
      if (accept) begin
        op_q   <= op_in;
        neg_q  <= neg_a ^ neg_b;
        rneg_q <= neg_a;
        mb_q   <= mb_in;
        cnt_q  <= is_w ? ITER_W : ITER_D;
`ifdef MULDIV_FAST_MUL_EN
        ma_q   <= ma_in;
`else
        mcand_q <= {64'b0, ma_in};
        acc_q   <= '0;
`endif
        if (special) result_q <= spec_res;
      end
      if (run_mul) begin
`ifndef MULDIV_FAST_MUL_EN
        acc_q   <= acc_nxt;
        mcand_q <= mcand_q << 1;
        mb_q    <= mb_q >> 1;
`endif
        if (mul_last) result_q <= mul_res;
      end
      if (run_div && last) result_q <= div_res;
      if ((run_mul || run_div) && !last) cnt_q <= cnt_q - 7'd1;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import common::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset, flush, start;
  logic [3:0]  op;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] last_res = '0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LM64 = 2;
  localparam int LM32 = 2;
`else
  localparam int LM64 = 65;
  localparam int LM32 = 33;
`endif
  localparam int LD64 = 65;
  localparam int LD32 = 33;
  localparam int LSP  = 1;

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("vec%0d_result", e.id), result, e.res);
          chk($sformatf("vec%0d_cycle", e.id), 64'(cyc), 64'(e.at));
        end
      end
    end
  endtask

  task automatic wait_drain(int id);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk($sformatf("vec%0d_timeout", id), 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic push_exp(int id, logic [63:0] ex, int lat);
    exp_t e;
    e.res = ex;
    e.at  = cyc + lat;
    e.id  = id;
    sb.push_back(e);
    last_res = ex;
  endtask

  task automatic issue(int id, muldiv_op_t o, logic [63:0] av, logic [63:0] bv,
                       logic [63:0] ex, int lat);
    @(negedge clk);
    op    = o;
    a     = av;
    b     = bv;
    start = 1'b1;
    push_exp(id, ex, lat);
    @(negedge clk);
    start = 1'b0;
    wait_drain(id);
  endtask

  int c0;

  initial begin
    reset = 1'b1; flush = 1'b0; start = 1'b0;
    op = 4'd0; a = '0; b = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result, 64'd0);
    reset = 1'b0;

    issue(1,  OP_DIV,    -64'sd7, 64'd2, -64'sd3, LD64);
    issue(2,  OP_REM,    -64'sd7, 64'd2, -64'sd1, LD64);
    issue(3,  OP_DIVU,   64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LSP);
    issue(4,  OP_REMU,   64'd100, 64'd0, 64'd100, LSP);
    issue(5,  OP_DIV,    64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, LSP);
    issue(6,  OP_REM,    64'h8000_0000_0000_0000, '1, 64'd0, LSP);
    issue(7,  OP_MULHU,  '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, LM64);
    issue(8,  OP_DIVUW,  64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, LD32);
    issue(9,  OP_MULW,   64'd65536, 64'd65536, 64'd0, LM32);
    issue(10, OP_MULH,   '1, '1, 64'd0, LM64);
    issue(11, OP_MULH,   -64'sd2, 64'd3, '1, LM64);
    issue(12, OP_MULHSU, '1, 64'd2, '1, LM64);
    issue(13, OP_MUL,    64'h1_0000_0001, 64'd3, 64'h3_0000_0003, LM64);
    issue(14, OP_MULW,   64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LM32);
    issue(15, OP_DIVW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LD32);
    issue(16, OP_REMW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, LD32);
    issue(17, OP_REMUW,  64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, LD32);
    issue(18, OP_DIVW,   64'd5, 64'hABCD_0000_0000_0000, '1, LSP);
    issue(19, OP_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, LSP);
    issue(20, OP_REMW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, LSP);
    issue(21, OP_DIVU,   64'd100, 64'd7, 64'd14, LD64);
    issue(22, OP_REMU,   64'd100, 64'd7, 64'd2, LD64);
    issue(23, OP_DIV,    64'd7, -64'sd2, -64'sd3, LD64);
    issue(24, OP_REM,    64'd7, -64'sd2, 64'd1, LD64);

    // Flush scenario: DIV started at T, ignored start at T+5, flush at T+10.
    @(negedge clk);
    c0    = cyc;
    op    = OP_DIV;
    a     = 64'd1000;
    b     = 64'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 5) @(negedge clk);
    op    = OP_MUL;
    a     = 64'd9;
    b     = 64'd9;
    start = 1'b1;
    chk("busy_at_t5", 64'(busy), 64'd1);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    chk("busy_at_t10", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_result", result, last_res);
    op    = OP_MUL;
    a     = 64'h1_0000_0001;
    b     = 64'd5;
    start = 1'b1;
    push_exp(25, 64'h5_0000_0005, LM64);
    @(negedge clk);
    start = 1'b0;
    wait_drain(25);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
